output_mems: RTL and testbench

- Result-side counterpart of the matrix input loader.
- Buffers the M x N result matrix C while the compute engine writes it.
- Once compute signals completion, streams C out as an AXI-Stream master, row-major, one element per beat, with TLAST on the final element.
- Sits between the compute/MAC array and the downstream AXIS consumer; C_ready gates when compute may write.

---
 rtl/output_mems.sv | 115 +++++++++++
 tb/tb_output_mems.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_mems.sv
`default_nettype none
// ============================================================================
//  Module      : output_mems
//  Description : Result-matrix buffer. Captures the M x N result matrix C from
//                the compute array, then streams it out row-major as an
//                AXI-Stream master, one element per beat, TLAST on the final
//                element.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_mems #(
    parameter  int OUTW        = 32,
    parameter  int M           = 7,
    parameter  int N           = 9,
    localparam int C_ADDR_BITS = $clog2(M * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [OUTW-1:0] C_wr_data,
    input  logic [C_ADDR_BITS-1:0] C_wr_addr,
    input  logic                   C_wr_en,
    input  logic                   compute_finished,
    output logic                   C_ready,
    output logic signed [OUTW-1:0] AXIS_TDATA,
    output logic                   AXIS_TVALID,
    input  logic                   AXIS_TREADY,
    output logic                   AXIS_TLAST
);

    localparam int                     MEM_DEPTH = 2 ** C_ADDR_BITS;
    localparam logic [C_ADDR_BITS-1:0] LAST_IDX  = C_ADDR_BITS'(M * N - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_SEND     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [C_ADDR_BITS-1:0] send_count_q, send_count_d;
    logic [C_ADDR_BITS-1:0] mem_addr;
    logic                   mem_we;

    logic signed [OUTW-1:0] mem_q [MEM_DEPTH];
    logic signed [OUTW-1:0] rd_data_q;

    // State and beat counter; asynchronous reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            send_count_q <= '0;
        end else begin
            state_q      <= state_d;
            send_count_q <= send_count_d;
        end
    end

    // Next state, memory port steering and stream outputs. In SEND the read
    // address looks one element ahead whenever the current beat is accepted,
    // so registered read data keeps pace with one beat per cycle.
    always_comb begin
        state_d      = state_q;
        send_count_d = send_count_q;
        mem_addr     = C_wr_addr;
        mem_we       = 1'b0;
        C_ready      = 1'b0;
        AXIS_TVALID  = 1'b0;
        AXIS_TLAST   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_addr = C_wr_addr;
                mem_we   = C_wr_en;
                C_ready  = 1'b1;
                if (compute_finished) begin
                    state_d      = ST_PREFETCH;
                    send_count_d = '0;
                end
            end
            ST_PREFETCH: begin
                mem_addr = '0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                AXIS_TVALID = 1'b1;
                AXIS_TLAST  = (send_count_q == LAST_IDX);
                if (AXIS_TREADY) begin
                    mem_addr = send_count_q + C_ADDR_BITS'(1);
                    if (send_count_q == LAST_IDX) begin
                        state_d      = ST_IDLE;
                        send_count_d = '0;
                    end else begin
                        send_count_d = send_count_q + C_ADDR_BITS'(1);
                    end
                end else begin
                    mem_addr = send_count_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                send_count_d = '0;
            end
        endcase
    end

    // Single-port result memory with registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= C_wr_data;
        end
        rd_data_q <= mem_q[mem_addr];
    end

    assign AXIS_TDATA = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_output_mems.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_mems
//  Description : Self-checking bench for output_mems (M=2, N=3). A memory
//                model tracks accepted writes; each compute_finished pushes
//                the expected frame onto a scoreboard queue that the stream
//                monitor drains beat by beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_mems;

    localparam int OUTW = 32;
    localparam int M    = 2;
    localparam int N    = 3;
    localparam int NE   = M * N;
    localparam int AW   = $clog2(NE);

    logic                   clk;
    logic                   reset;
    logic signed [OUTW-1:0] C_wr_data;
    logic [AW-1:0]          C_wr_addr;
    logic                   C_wr_en;
    logic                   compute_finished;
    logic                   C_ready;
    logic signed [OUTW-1:0] AXIS_TDATA;
    logic                   AXIS_TVALID;
    logic                   AXIS_TREADY;
    logic                   AXIS_TLAST;

    typedef struct {
        logic [OUTW-1:0] data;
        logic            last;
    } beat_t;

    beat_t           sb_q[$];
    logic [OUTW-1:0] model_mem [NE];
    int              err_cnt = 0;
    int              chk_cnt = 0;
    int              beats   = 0;

    output_mems #(.OUTW(OUTW), .M(M), .N(N)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .C_wr_data        (C_wr_data),
        .C_wr_addr        (C_wr_addr),
        .C_wr_en          (C_wr_en),
        .compute_finished (compute_finished),
        .C_ready          (C_ready),
        .AXIS_TDATA       (AXIS_TDATA),
        .AXIS_TVALID      (AXIS_TVALID),
        .AXIS_TREADY      (AXIS_TREADY),
        .AXIS_TLAST       (AXIS_TLAST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [OUTW-1:0] obs,
                             input logic [OUTW-1:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < NE; i++) begin
            beat_t b;
            b.data = model_mem[i];
            b.last = (i == NE - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic write_elem(input int addr, input logic [OUTW-1:0] data);
        C_wr_en   = 1'b1;
        C_wr_addr = AW'(addr);
        C_wr_data = data;
        model_mem[addr] = data;
        @(posedge clk); #1;
        C_wr_en = 1'b0;
    endtask

    task automatic start_frame();
        compute_finished = 1'b1;
        push_frame();
        @(posedge clk); #1;
        compute_finished = 1'b0;
    endtask

    task automatic write_and_start(input int addr, input logic [OUTW-1:0] data);
        C_wr_en          = 1'b1;
        C_wr_addr        = AW'(addr);
        C_wr_data        = data;
        compute_finished = 1'b1;
        model_mem[addr]  = data;
        push_frame();
        @(posedge clk); #1;
        C_wr_en          = 1'b0;
        compute_finished = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!C_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, {31'b0, C_ready}, 1);
        check_val({tag, "_drained"}, OUTW'(sb_q.size()), 0);
    endtask

    // Stream monitor: every valid beat must match the scoreboard head; the
    // head is consumed only when the beat is accepted, so stalls re-check it.
    always @(negedge clk) begin
        if (reset && AXIS_TVALID) begin
            check_val("sb_avail", {31'b0, sb_q.size() != 0}, 1);
            if (sb_q.size() != 0) begin
                check_val("tdata", AXIS_TDATA, sb_q[0].data);
                check_val("tlast", {31'b0, AXIS_TLAST}, {31'b0, sb_q[0].last});
                if (AXIS_TREADY) begin
                    void'(sb_q.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   b0;
        logic pat [8];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        reset            = 1'b0;
        C_wr_data        = '0;
        C_wr_addr        = '0;
        C_wr_en          = 1'b0;
        compute_finished = 1'b0;
        AXIS_TREADY      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_c_ready", {31'b0, C_ready}, 1);
        check_val("rst_tvalid", {31'b0, AXIS_TVALID}, 0);
        check_val("rst_tlast", {31'b0, AXIS_TLAST}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: basic frame, latency and TLAST placement
        for (int i = 0; i < NE; i++) write_elem(i, OUTW'(100 + i));
        AXIS_TREADY = 1'b1;
        b0 = beats;
        start_frame();
        check_val("t1_prefetch_tvalid", {31'b0, AXIS_TVALID}, 0);
        check_val("t1_prefetch_c_ready", {31'b0, C_ready}, 0);
        @(posedge clk); #1;
        check_val("t1_first_tvalid", {31'b0, AXIS_TVALID}, 1);
        check_val("t1_first_tdata", AXIS_TDATA, 100);
        repeat (5) @(posedge clk);
        #1;
        check_val("t1_last_tlast", {31'b0, AXIS_TLAST}, 1);
        check_val("t1_last_tdata", AXIS_TDATA, 105);
        @(posedge clk); #1;
        check_val("t1_idle_c_ready", {31'b0, C_ready}, 1);
        check_val("t1_idle_tvalid", {31'b0, AXIS_TVALID}, 0);
        check_val("t1_beats", OUTW'(beats - b0), NE);

        // 2: irregular TREADY pattern
        AXIS_TREADY = 1'b0;
        b0 = beats;
        start_frame();
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            AXIS_TREADY = pat[i];
            @(posedge clk); #1;
        end
        AXIS_TREADY = 1'b1;
        wait_idle("t2_idle");
        check_val("t2_beats", OUTW'(beats - b0), NE);

        // 3: writes and compute_finished during SEND are ignored
        b0 = beats;
        start_frame();
        @(posedge clk); #1;
        C_wr_en          = 1'b1;
        C_wr_addr        = '0;
        C_wr_data        = 999;
        compute_finished = 1'b1;
        check_val("t3_c_ready", {31'b0, C_ready}, 0);
        @(posedge clk); #1;
        C_wr_en          = 1'b0;
        compute_finished = 1'b0;
        check_val("t3_c_ready_after", {31'b0, C_ready}, 0);
        wait_idle("t3_idle");
        repeat (3) @(posedge clk);
        #1;
        check_val("t3_no_extra_frame", {31'b0, AXIS_TVALID}, 0);
        start_frame();
        @(posedge clk); #1;
        check_val("t3_beat0", AXIS_TDATA, 100);
        wait_idle("t3_idle2");
        check_val("t3_beats", OUTW'(beats - b0), 2 * NE);

        // 4: asynchronous reset mid-frame
        b0 = beats;
        start_frame();
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check_val("t4_beats_before", OUTW'(beats - b0), 3);
        #2;
        reset = 1'b0;
        #1;
        check_val("t4_async_tvalid", {31'b0, AXIS_TVALID}, 0);
        check_val("t4_async_c_ready", {31'b0, C_ready}, 1);
        check_val("t4_async_tlast", {31'b0, AXIS_TLAST}, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        b0 = beats;
        start_frame();
        @(posedge clk); #1;
        check_val("t4_restart_beat0", AXIS_TDATA, 100);
        wait_idle("t4_idle");
        check_val("t4_beats", OUTW'(beats - b0), NE);

        // 6: long stall on the first beat
        AXIS_TREADY = 1'b0;
        b0 = beats;
        start_frame();
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            check_val("t6_stall_tdata", AXIS_TDATA, 100);
            check_val("t6_stall_tlast", {31'b0, AXIS_TLAST}, 0);
            @(posedge clk); #1;
        end
        AXIS_TREADY = 1'b1;
        wait_idle("t6_idle");
        check_val("t6_beats", OUTW'(beats - b0), NE);

        // 5: write coinciding with compute_finished, then back-to-back frames
        b0 = beats;
        write_and_start(NE - 1, 32'hFFFF_FFFB);
        repeat (7) @(posedge clk);
        #1;
        check_val("t5_first_idle", {31'b0, C_ready}, 1);
        check_val("t5_drained", OUTW'(sb_q.size()), 0);
        for (int i = 0; i < NE - 1; i++) write_elem(i, OUTW'(200 + i));
        write_and_start(NE - 1, OUTW'(200 + NE - 1));
        wait_idle("t5_idle");
        start_frame();
        @(posedge clk); #1;
        check_val("t5_b2b_beat0", AXIS_TDATA, 200);
        wait_idle("t5_idle2");
        check_val("t5_beats", OUTW'(beats - b0), 3 * NE);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
